// File: rtl/pb_capture_pkg.sv
// Shared definitions for the push-button capture peripheral.
//   - Avalon word addresses of the four registers
//   - cnt_width(): width of a counter that must hold 0 .. cycles-1
// Optional build macro used by the peripheral: PB_RELEASE_CAPTURE_EN.
package pb_capture_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_AUX      = 2'd3;

    // The counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    // Clamp to one bit so that small counts still give a legal vector.
    function automatic int cnt_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pb_capture_avmm_if.sv
// Avalon-MM slave bus of the push-button capture peripheral.
//   avs_address   [1:0]  word address
//   avs_read             read strobe
//   avs_write            write strobe
//   avs_writedata [31:0] write data
//   avs_readdata  [31:0] read data, fixed read latency 1, no waitrequest
// Modports: master (Nios side) and slave (peripheral side).
interface pb_capture_avmm_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/pb_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce counter, stable level.
//   clk, rst_n     clock and asynchronous active-low reset
//   pb_raw         raw active-low button, asynchronous to clk
//   sample         synchronized button level (s)
//   stable         debounced level, 1 = released
//   press_pulse    one-cycle pulse on the clock where stable goes 1->0
//   release_pulse  one-cycle pulse on the clock where stable goes 0->1
module pb_debounce_ch
    import pb_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_raw,
    output logic sample,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] count;
    logic          terminal;

    // The level flips on the clock where a disagreement has persisted long
    // enough; both event pulses are decoded from that same condition so they
    // line up with the edge that updates stable.
    assign terminal      = (sync_p1 != stable) && (count == TERM);
    assign press_pulse   = terminal && stable;
    assign release_pulse = terminal && !stable;
    assign sample        = sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            stable  <= 1'b1;
            count   <= '0;
        end else begin
            // synchronizer stage
            sync_p0 <= pb_raw;
            sync_p1 <= sync_p0;
            // debounce stage: any agreement with stable restarts the count
            if (sync_p1 == stable) begin
                count <= '0;
            end else if (count == TERM) begin
                stable <= sync_p1;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pb_capture_avmm.sv
// Avalon-MM responder for the active-low user push buttons.
//   SYS_CLK50M  system clock (sole clock)
//   RESET_EXPN  asynchronous active-low reset
//   PB          raw active-low buttons
//   avs         Avalon-MM slave bus (pb_capture_avmm_if.slave)
//   irq         level interrupt = |(captured events & irq_mask), registered
//   pb_pressed  debounced levels, 1 = pressed (for USER_LED drive)
// Register map: 0 DATA (ro), 1 IRQ_MASK (rw), 2 EDGE_CAPTURE (w1c),
//   3 RAW synchronized level (ro), or RELEASE_CAPTURE (w1c) when the build
//   macro PB_RELEASE_CAPTURE_EN is defined.
module pb_capture_avmm
    import pb_capture_pkg::*;
#(
    parameter int NUM_PB          = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              SYS_CLK50M,
    input  logic              RESET_EXPN,
    input  logic [NUM_PB-1:0] PB,
    pb_capture_avmm_if.slave  avs,
    output logic              irq,
    output logic [NUM_PB-1:0] pb_pressed
);

    logic [NUM_PB-1:0] sample;
    logic [NUM_PB-1:0] stable;
    logic [NUM_PB-1:0] press;
    logic [NUM_PB-1:0] release_ev;
    logic [NUM_PB-1:0] edge_cap;
    logic [NUM_PB-1:0] irq_mask;
    logic [NUM_PB-1:0] edge_clr;
    logic [NUM_PB-1:0] pending;
    logic [31:0]       rd_word;
    logic              unused_bits;

    for (genvar ch = 0; ch < NUM_PB; ch++) begin : g_ch
        pb_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk          (SYS_CLK50M),
            .rst_n        (RESET_EXPN),
            .pb_raw       (PB[ch]),
            .sample       (sample[ch]),
            .stable       (stable[ch]),
            .press_pulse  (press[ch]),
            .release_pulse(release_ev[ch])
        );
    end

    assign pb_pressed = ~stable;

    assign edge_clr = (avs.avs_write && avs.avs_address == ADDR_EDGE_CAP)
                    ? avs.avs_writedata[NUM_PB-1:0] : '0;

`ifdef PB_RELEASE_CAPTURE_EN
    logic [NUM_PB-1:0] rel_cap;
    logic [NUM_PB-1:0] rel_clr;

    assign rel_clr = (avs.avs_write && avs.avs_address == ADDR_AUX)
                   ? avs.avs_writedata[NUM_PB-1:0] : '0;
    assign pending = (edge_cap | rel_cap) & irq_mask;
    assign unused_bits = ^{avs.avs_writedata[31:NUM_PB], sample};

    // Clear first, then OR in the new event so a same-cycle event wins.
    always_ff @(posedge SYS_CLK50M or negedge RESET_EXPN) begin
        if (!RESET_EXPN) rel_cap <= '0;
        else             rel_cap <= (rel_cap & ~rel_clr) | release_ev;
    end
`else
    assign pending = edge_cap & irq_mask;
    assign unused_bits = ^{avs.avs_writedata[31:NUM_PB], release_ev};
`endif

    // Read mux sees the registers before this clock's updates, which gives
    // the pre-event / pre-write read semantics for free.
    always_comb begin
        rd_word = '0;
        case (avs.avs_address)
            ADDR_DATA:     rd_word[NUM_PB-1:0] = ~stable;
            ADDR_IRQ_MASK: rd_word[NUM_PB-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_word[NUM_PB-1:0] = edge_cap;
`ifdef PB_RELEASE_CAPTURE_EN
            ADDR_AUX:      rd_word[NUM_PB-1:0] = rel_cap;
`else
            ADDR_AUX:      rd_word[NUM_PB-1:0] = ~sample;
`endif
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge SYS_CLK50M or negedge RESET_EXPN) begin
        if (!RESET_EXPN) begin
            edge_cap         <= '0;
            irq_mask         <= '0;
            irq              <= 1'b0;
            avs.avs_readdata <= '0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | press;
            if (avs.avs_write && avs.avs_address == ADDR_IRQ_MASK)
                irq_mask <= avs.avs_writedata[NUM_PB-1:0];
            irq              <= |pending;
            avs.avs_readdata <= avs.avs_read ? rd_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_pb_capture_avmm.sv
// Scoreboard bench for pb_capture_avmm (NUM_PB=4, DEBOUNCE_CYCLES=8).
// The driver applies one set of inputs per clock, advances a behavioural
// model and queues the outputs expected after that clock; the monitor pops
// one entry per clock on the falling edge and compares.
// Debounce reference: a channel's level flips on clock n when the PB samples
// taken at clocks n-DEB-1 .. n-2 all disagree with the current level.
// Honours PB_RELEASE_CAPTURE_EN the same way as the design.
module tb_pb_capture_avmm;

    localparam int NUM_PB = 4;
    localparam int DEB    = 8;

    typedef struct {
        logic [31:0]       rdata;
        logic              irq;
        logic [NUM_PB-1:0] pressed;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_PB-1:0] pb;
    logic              irq;
    logic [NUM_PB-1:0] pb_pressed;

    int vectors = 0;
    int miscompares = 0;

    exp_t              exp_q[$];
    logic [NUM_PB-1:0] hist[$];
    logic [NUM_PB-1:0] m_stable;
    logic [NUM_PB-1:0] m_ecap;
    logic [NUM_PB-1:0] m_rcap;
    logic [NUM_PB-1:0] m_mask;

    pb_capture_avmm_if bus ();

    pb_capture_avmm #(
        .NUM_PB         (NUM_PB),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .SYS_CLK50M(clk),
        .RESET_EXPN(rst_n),
        .PB        (pb),
        .avs       (bus),
        .irq       (irq),
        .pb_pressed(pb_pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, got, want);
        end
    endtask

    // Monitor: one expected record per clock.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("readdata",   bus.avs_readdata,  e.rdata);
            check("irq",        32'(irq),          32'(e.irq));
            check("pb_pressed", 32'(pb_pressed),   32'(e.pressed));
        end
    end

    task automatic model_reset();
        m_stable = '1;
        m_ecap   = '0;
        m_rcap   = '0;
        m_mask   = '0;
        hist.delete();
        repeat (DEB + 2) hist.push_back('1);
    endtask

    task automatic model_edge(output exp_t e);
        logic [NUM_PB-1:0] s_pre, flip, clr, rclr, wd;
        logic [31:0]       rd;
        s_pre = hist[hist.size()-2];
        wd    = bus.avs_writedata[NUM_PB-1:0];
        rd    = '0;
        if (bus.avs_read) begin
            case (bus.avs_address)
                2'd0: rd[NUM_PB-1:0] = ~m_stable;
                2'd1: rd[NUM_PB-1:0] = m_mask;
                2'd2: rd[NUM_PB-1:0] = m_ecap;
`ifdef PB_RELEASE_CAPTURE_EN
                default: rd[NUM_PB-1:0] = m_rcap;
`else
                default: rd[NUM_PB-1:0] = ~s_pre;
`endif
            endcase
        end
        e.rdata = rd;
`ifdef PB_RELEASE_CAPTURE_EN
        e.irq = |((m_ecap | m_rcap) & m_mask);
`else
        e.irq = |(m_ecap & m_mask);
`endif
        for (int ch = 0; ch < NUM_PB; ch++) begin
            flip[ch] = 1'b1;
            for (int k = 1; k <= DEB; k++)
                if (hist[hist.size()-1-k][ch] == m_stable[ch]) flip[ch] = 1'b0;
        end
        clr  = (bus.avs_write && bus.avs_address == 2'd2) ? wd : '0;
        rclr = (bus.avs_write && bus.avs_address == 2'd3) ? wd : '0;
        m_ecap = (m_ecap & ~clr) | (flip & m_stable);
`ifdef PB_RELEASE_CAPTURE_EN
        m_rcap = (m_rcap & ~rclr) | (flip & ~m_stable);
`else
        m_rcap = rclr & '0;
`endif
        if (bus.avs_write && bus.avs_address == 2'd1) m_mask = wd;
        m_stable  = m_stable ^ flip;
        e.pressed = ~m_stable;
        hist.push_back(pb);
        if (hist.size() > DEB + 4) void'(hist.pop_front());
    endtask

    // One clock: model the coming edge with the inputs now applied.
    task automatic cyc();
        exp_t e;
        if (!rst_n) begin
            model_reset();
            e.rdata = '0; e.irq = 1'b0; e.pressed = '0;
        end else begin
            model_edge(e);
        end
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_read(input logic [1:0] a);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        cyc();
        bus.avs_read    = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        cyc();
        bus.avs_write     = 1'b0;
    endtask

    initial begin
        int hold[NUM_PB];
        rst_n = 1'b0;
        pb    = '1;
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        for (int a = 0; a < 4; a++) do_read(2'(a));

        // PB[0] press held
        pb[0] = 1'b0;
        wait_cyc(14);
        do_read(2'd2); do_read(2'd0);

        // PB[1] bounce, then held low
        pb[1] = 1'b0; wait_cyc(5);
        pb[1] = 1'b1; wait_cyc(2);
        pb[1] = 1'b0; wait_cyc(14);
        do_read(2'd2); do_read(2'd0);

        // mask, fresh PB[1] press, interrupt, clear
        do_write(2'd2, 32'hF);
        do_write(2'd1, 32'h3);
        pb[1] = 1'b1; wait_cyc(14);
        pb[1] = 1'b0; wait_cyc(14);
        do_read(2'd2);
        do_write(2'd2, 32'h2);
        wait_cyc(2);
        do_read(2'd2);

        // clear-write on the very clock of the PB[2] press event
        pb[2] = 1'b0;
        wait_cyc(DEB + 1);
        do_write(2'd2, 32'h4);
        do_read(2'd2);

        // reset in the middle of a PB[3] count
        pb[3] = 1'b0;
        wait_cyc(5);
        rst_n = 1'b0; wait_cyc(2);
        rst_n = 1'b1; wait_cyc(14);
        do_read(2'd2);
        pb[3] = 1'b1; wait_cyc(14);
        do_read(2'd3);

        // randomized traffic and bouncing buttons
        for (int ch = 0; ch < NUM_PB; ch++) hold[ch] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NUM_PB; ch++) begin
                if (hold[ch] == 0) begin
                    pb[ch]   = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 14);
                end else begin
                    hold[ch]--;
                end
            end
            rst_n             = !(i == 700 || i == 701);
            bus.avs_address   = 2'($urandom_range(0, 3));
            bus.avs_read      = ($urandom_range(0, 2) == 0);
            bus.avs_write     = ($urandom_range(0, 4) == 0);
            bus.avs_writedata = $urandom;
            cyc();
        end
        bus.avs_read = 1'b0; bus.avs_write = 1'b0; rst_n = 1'b1;
        wait_cyc(2);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
